// File: rtl/err_accumulator.sv
// Per-channel error accumulator. Each channel keeps either a running sum of
// squared differences (mode 0) or the largest absolute difference (mode 1)
// between a DUT stream and a reference stream. A run covers SEQ_LEN accepted
// samples, and the per-channel results are presented for one cycle.
module err_accumulator #(
  parameter int DATA_W      = 29,
  parameter int NCH         = 4,
  parameter int SEQ_LEN     = 131072,
  parameter int ACC_W       = 78,
  parameter int OUT_LSB     = 13,
  parameter int OUT_W       = 64,
  parameter bit DATA_SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  input  logic [NCH*DATA_W-1:0] data_in,
  input  logic [NCH*DATA_W-1:0] data_ref,
  output logic                  busy,
  output logic [NCH*OUT_W-1:0]  data_out,
  output logic                  data_valid,
  output logic [NCH-1:0]        ovf
);

  // One guard bit holds the full difference range; the square of that
  // difference always fits in twice the guarded width.
  localparam int DIFF_W = DATA_W + 1;
  localparam int SQ_W   = 2 * DATA_W + 2;
  localparam int CNT_W  = $clog2(SEQ_LEN + 1);
  localparam int TOP    = OUT_LSB + OUT_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_count;
  logic               r_drainCnt;
  logic               r_mode;
  logic               r_v1;
  logic               r_v2;
  logic               w_accept;
  logic               w_clear;
  logic               w_last;

  assign w_clear    = (r_state == IDLE) && start;
  assign w_accept   = (r_state == ACCUM) && in_valid;
  assign w_last     = w_accept && (r_count == CNT_W'(SEQ_LEN - 1));
  assign busy       = (r_state == ACCUM) || (r_state == DRAIN);
  assign data_valid = (r_state == DONE);

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: DRAIN lets the last sample ripple through both
  // pipeline stages into the accumulator before DONE shows the result.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = DRAIN;
      DRAIN:   if (r_drainCnt) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Run control: sample counter, drain timer and the mode latched at start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count    <= '0;
      r_drainCnt <= 1'b0;
      r_mode     <= 1'b0;
    end else begin
      if (w_clear) begin
        r_count <= '0;
        r_mode  <= mode;
      end else if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (r_state == DRAIN) r_drainCnt <= ~r_drainCnt;
      else                  r_drainCnt <= 1'b0;
    end
  end

  // Valid tags that follow accepted samples through the two pipeline stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] w_ref;
    logic [DIFF_W-1:0] w_inExt;
    logic [DIFF_W-1:0] w_refExt;
    logic [DIFF_W-1:0] r_diff;
    logic [DIFF_W-1:0] w_abs;
    logic [SQ_W-1:0]   w_dExt;
    logic [SQ_W-1:0]   w_sq;
    logic [SQ_W-1:0]   r_stage2;
    logic [ACC_W-1:0]  w_s2Ext;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  r_acc;
    logic              r_sat;
    logic              w_high;
    logic [OUT_W-1:0]  w_res;

    assign w_in     = data_in[k*DATA_W +: DATA_W];
    assign w_ref    = data_ref[k*DATA_W +: DATA_W];
    assign w_inExt  = DATA_SIGNED ? {w_in[DATA_W-1], w_in}   : {1'b0, w_in};
    assign w_refExt = DATA_SIGNED ? {w_ref[DATA_W-1], w_ref} : {1'b0, w_ref};

    // The guarded difference is always a two's-complement value, so the
    // sign-extended product wraps to the exact square in SQ_W bits.
    assign w_dExt  = {{(SQ_W-DIFF_W){r_diff[DIFF_W-1]}}, r_diff};
    assign w_sq    = w_dExt * w_dExt;
    assign w_abs   = r_diff[DIFF_W-1] ? (DIFF_W'(0) - r_diff) : r_diff;
    assign w_s2Ext = ACC_W'(r_stage2);
    assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_stage2);

    // Stage 1 captures ref - in; stage 2 turns it into square or magnitude.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_diff   <= '0;
        r_stage2 <= '0;
      end else begin
        if (w_accept) r_diff <= w_refExt - w_inExt;
        if (r_v1)     r_stage2 <= r_mode ? SQ_W'(w_abs) : w_sq;
      end
    end

    // Accumulator: saturating sum in mode 0, running maximum in mode 1.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (w_clear) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (r_v2) begin
        if (!r_mode) begin
          if (w_sum[ACC_W]) begin
            r_acc <= '1;
            r_sat <= 1'b1;
          end else begin
            r_acc <= w_sum[ACC_W-1:0];
          end
        end else if (w_s2Ext > r_acc) begin
          r_acc <= w_s2Ext;
        end
      end
    end

    if (TOP < ACC_W) begin : g_hi
      assign w_high = |r_acc[ACC_W-1:TOP];
    end else begin : g_noHi
      assign w_high = 1'b0;
    end

    assign w_res = w_high ? '1 : r_acc[OUT_LSB +: OUT_W];
    assign data_out[k*OUT_W +: OUT_W] = data_valid ? w_res : '0;
    assign ovf[k] = data_valid & (r_sat | w_high);
  end

endmodule
